piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
Parallel-in serial-out shift register. It captures a WIDTH-bit word on a load strobe and emits it one bit per clock on a single serial line, MSB first by default. Status outputs give a busy flag and a one-cycle done pulse. It sits between a parallel data source and a bit-serial link or serializer stage.

Parameters:
WIDTH, 8, parallel word width in bits (≥2).
MSB_FIRST, 1, 1 = shift out in[WIDTH-1] first, 0 = shift out in[0] first.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  reset, synchronous and active-low: sampled on the rising edge of clk, asserted when 0.
load  input  1  parallel load strobe, sampled on the rising edge.
in  input  WIDTH  parallel data word, sampled only when load=1.
out  output  1  serial data bit.
busy  output  1  high while loaded bits remain to be shifted out.
done  output  1  one-cycle pulse after the last bit has been shifted out.

Behaviour:
- State: shift register sreg[WIDTH-1:0]; bit counter rem, range 0..WIDTH, width clog2(WIDTH+1); registered done_r.
- out is combinational from sreg: sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0]. No extra latency.
- busy = (rem != 0). done = done_r.
- Priority per rising edge: reset > load > shift.
- Reset (rst=0 at edge): sreg=0, rem=0, done_r=0. Therefore out=0, busy=0, done=0. Reset overrides a simultaneous load. Reset mid-transfer aborts the transfer; the remaining bits are lost.
- Load (rst=1, load=1): sreg<=in, rem<=WIDTH, done_r<=0.
  - The first serial bit is valid on out in the cycle immediately after the load edge.
  - A load while busy restarts the transfer with the new word; no done pulse is issued for the aborted word.
- Shift (rst=1, load=0): this happens every edge, whether busy or not.
  - MSB_FIRST=1: sreg<={sreg[WIDTH-2:0],1'b0}. MSB_FIRST=0: sreg<={1'b0,sreg[WIDTH-1:1]}. Zero fill.
  - If rem!=0, rem<=rem-1.
  - done_r<=1 exactly when rem==1 at this edge; otherwise done_r<=0.
- Timeline after a load at edge E0:
  - Bit k (k=0 is the first transmitted bit) is on out between edges Ek and Ek+1, for k=0..WIDTH-1.
  - At edge E(WIDTH): out=0, busy=0, done=1 for one cycle.
- Idle (rem=0, no load): sreg stays 0 after a full drain, so out=0. busy=0, done=0.
- load held high for multiple cycles: the word is reloaded each edge; out holds the first bit and rem stays WIDTH.
- in is don't-care when load=0.

Test Plan:
1. Reset: hold rst=0 for 2 edges with load=1 and in=8'hFF -> out=0, busy=0, done=0. The load is ignored.
2. Basic MSB-first (WIDTH=8): load 8'b10110001 for one edge, then load=0 -> out over the next 8 cycles = 1,0,1,1,0,0,0,1. busy=1 during those 8 cycles. At the 9th cycle out=0, busy=0, done=1 for exactly one cycle.
3. Reset mid-transfer: load 8'b10110001, shift 5 edges, then rst=0 for one edge -> out=0, busy=0, done never asserts. Subsequent idle cycles keep out=0.
4. Reload while busy: load 8'b10110001, after 3 shifts load 8'b10101010 -> out becomes 1,0,1,0,1,0,1,0 from the cycle after the second load. Exactly one done pulse, 8 cycles after the second load.
5. LSB-first (MSB_FIRST=0): load 8'b10110001 -> out = 1,0,0,0,1,1,0,1, then 0 with a done pulse.
6. Reset vs load collision: rst=0 and load=1 on the same edge, then rst=1 and load=0 -> out=0, busy=0. No transfer occurs.

Source files
------------

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register: captures a word on load and streams it
// out one bit per clock, with busy and a one-cycle done pulse after the last bit.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;

  always_comb begin
    sreg_d = sreg_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    if (load) begin
      sreg_d = in;
      rem_d  = CW'(WIDTH);
    end else begin
      // Shifting runs every cycle; once drained the zero fill keeps out low.
      if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      if (rem_q != '0) rem_d = rem_q - CW'(1);
      done_d = (rem_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign out  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign busy = (rem_q != '0);
  assign done = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: MSB-first and LSB-first instances share stimulus,
// checked against fixed vectors and a bit-queue reference model.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = '0;
  logic       out_m, busy_m, done_m;
  logic       out_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .in(din),
    .out(out_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .in(din),
    .out(out_l), .busy(busy_l), .done(done_l)
  );

  // Reference model: the bits still to be sent, in transmission order.
  bit qm[$];
  bit ql[$];
  bit mdone = 1'b0;

  task automatic model_edge(input logic r, input logic l, input logic [7:0] d);
    if (!r) begin
      qm.delete(); ql.delete(); mdone = 1'b0;
    end else if (l) begin
      qm.delete(); ql.delete();
      for (int k = 0; k < 8; k++) begin
        qm.push_back(d[7-k]);
        ql.push_back(d[k]);
      end
      mdone = 1'b0;
    end else begin
      mdone = (qm.size() == 1);
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " out_msb"},  out_m,  qm.size() > 0 ? logic'(qm[0]) : 1'b0);
    check({tag, " busy_msb"}, busy_m, qm.size() > 0);
    check({tag, " done_msb"}, done_m, mdone);
    check({tag, " out_lsb"},  out_l,  ql.size() > 0 ? logic'(ql[0]) : 1'b0);
    check({tag, " busy_lsb"}, busy_l, ql.size() > 0);
    check({tag, " done_lsb"}, done_l, mdone);
  endtask

  // Drive inputs, take one rising edge, then compare at the falling edge.
  task automatic step(input logic r, input logic l, input logic [7:0] d, input string tag);
    rst = r; load = l; din = d;
    @(posedge clk);
    model_edge(r, l, d);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       out_m;
    logic       out_l;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic l, input logic [7:0] d,
                              input logic om, input logic ol, input logic b, input logic dn);
    vec_t v;
    v.rst = r; v.load = l; v.din = d;
    v.out_m = om; v.out_l = ol; v.busy = b; v.done = dn;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int ndone;
    int done_at;

    // Reset with load asserted: load ignored.
    add(1'b0, 1'b1, 8'hFF, 0, 0, 0, 0);
    add(1'b0, 1'b1, 8'hFF, 0, 0, 0, 0);
    // 10110001: MSB order 1,0,1,1,0,0,0,1; LSB order 1,0,0,0,1,1,0,1.
    add(1'b1, 1'b1, 8'b10110001, 1, 1, 1, 0);
    add(1'b1, 1'b0, 8'h00, 0, 0, 1, 0);
    add(1'b1, 1'b0, 8'hFF, 1, 0, 1, 0);
    add(1'b1, 1'b0, 8'h00, 1, 0, 1, 0);
    add(1'b1, 1'b0, 8'h5A, 0, 1, 1, 0);
    add(1'b1, 1'b0, 8'h00, 0, 1, 1, 0);
    add(1'b1, 1'b0, 8'h00, 0, 0, 1, 0);
    add(1'b1, 1'b0, 8'h00, 1, 1, 1, 0);
    add(1'b1, 1'b0, 8'h00, 0, 0, 0, 1);
    add(1'b1, 1'b0, 8'h00, 0, 0, 0, 0);
    // Reset and load on the same edge: no transfer.
    add(1'b0, 1'b1, 8'hA5, 0, 0, 0, 0);
    add(1'b1, 1'b0, 8'h00, 0, 0, 0, 0);
    add(1'b1, 1'b0, 8'h00, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].load, tbl[i].din, $sformatf("vec%0d model", i));
      check($sformatf("vec%0d out_msb", i), out_m, tbl[i].out_m);
      check($sformatf("vec%0d out_lsb", i), out_l, tbl[i].out_l);
      check($sformatf("vec%0d busy", i), busy_m, tbl[i].busy);
      check($sformatf("vec%0d done", i), done_m, tbl[i].done);
    end

    // Reset mid-transfer: remaining bits lost, no done pulse.
    step(1'b1, 1'b1, 8'b10110001, "abort load");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, "abort shift");
    step(1'b0, 1'b0, 8'h00, "abort rst");
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'h00, "abort idle");
      if (done_m || done_l) ndone++;
      check("abort idle out", out_m, 1'b0);
    end
    check("abort no done", ndone == 0, 1'b1);

    // Reload while busy: new word restarts, single done pulse 8 cycles later.
    w2 = 8'b10101010;
    step(1'b1, 1'b1, 8'b10110001, "reload first");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, "reload shift");
    step(1'b1, 1'b1, w2, "reload second");
    check("reload bit0", out_m, w2[7]);
    ndone = 0;
    done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 8'h00, "reload drain");
      if (i < 8) check($sformatf("reload bit%0d", i), out_m, w2[7-i]);
      if (done_m) begin ndone++; done_at = i; end
    end
    check("reload one done", ndone == 1, 1'b1);
    check("reload done at 8", done_at == 8, 1'b1);

    // Held load keeps reloading: out holds first bit, busy stays high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h3C, "held load");
      check("held out_msb", out_m, 1'b0);
      check("held out_lsb", out_l, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0), w, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
